// File: rtl/alu_operand_feeder.sv
// Operand FIFO in front of a combinational ALU, with a registered result stage and valid/ready on both sides.
// Defining ALU_FEEDER_STATS_EN adds a 32-bit op_count output counting consumed results.
module alu_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [AW:0]      count
`ifdef ALU_FEEDER_STATS_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [2*WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic [AW:0]        count_next;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_result_reg;
  logic               not_empty;
  logic               push;
  logic               cap;

  // in_ready looks only at registered occupancy, so out_ready never reaches it combinationally.
  assign not_empty = (count_reg != '0);
  assign in_ready  = (count_reg != FULL_COUNT);
  assign push      = in_valid & in_ready;
  assign cap       = not_empty & (!out_valid_reg | out_ready);

  assign {alu_a, alu_b} = not_empty ? mem_reg[rd_ptr_reg] : '0;

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign count      = count_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !cap) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (cap && !push) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_reg[wr_ptr_reg] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (cap) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        out_result_reg <= alu_result;
        out_valid_reg  <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef ALU_FEEDER_STATS_EN
  logic [31:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      op_count_reg <= op_count_reg + 32'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_operand_feeder.sv
// Directed bench for alu_operand_feeder: single-op vector table plus back-pressure, streaming, wrap and reset sequences.
// The ALU is modelled as an 8-bit adder; op_count checks are built only with ALU_FEEDER_STATS_EN.
module tb_alu_operand_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] count;
`ifdef ALU_FEEDER_STATS_EN
  logic [31:0] op_count;
`endif

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;

  alu_operand_feeder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .count      (count)
`ifdef ALU_FEEDER_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] src_a [16];
  logic [7:0] src_b [16];
  logic [7:0] exp_q [$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         max_cnt;
  int         ops_cycles;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // Pushes src[0..n_push-1] holding each pair until accepted, and checks n_expect results against exp_q.
  task automatic run_ops(input int n_push, input int n_expect, input int stall_pct);
    int idx = 0;
    int got = 0;
    int extra = 0;
    int cyc = 0;
    logic [7:0] exp_r;
    max_cnt = 0;
    while (got < n_expect && cyc < 2000) begin
      in_valid  = (idx < n_push);
      in_a      = src_a[idx % 16];
      in_b      = src_b[idx % 16];
      out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          exp_r = exp_q.pop_front();
          $display("result %0d, model %0d", out_result, exp_r);
          chk("result_order", out_result, exp_r);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(8'(in_a + in_b));
        idx++;
      end
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    chk("ops_completed", got, n_expect);
    chk("extra_results", extra, 0);
    chk("pairs_pushed", idx, n_push);
    ops_cycles = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd10,  8'd5,   8'd15};
    vecs[1] = '{8'd200, 8'd100, 8'd44};
    vecs[2] = '{8'd0,   8'd0,   8'd0};
    vecs[3] = '{8'd255, 8'd1,   8'd0};
    vecs[4] = '{8'd255, 8'd255, 8'd254};
    vecs[5] = '{8'd128, 8'd128, 8'd0};
    vecs[6] = '{8'd7,   8'd9,   8'd16};

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);

    // Single-op table: push at edge k, result after k+1, released after k+2
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      cycle();
      in_valid = 1'b0;
      chk("single_count_k", count, 1);
      chk("single_valid_k", out_valid, 0);
      chk("single_alu_a", alu_a, vecs[i].a);
      chk("single_alu_b", alu_b, vecs[i].b);
      cycle();
      $display("op %0d+%0d -> %0d (model %0d)", vecs[i].a, vecs[i].b, out_result, vecs[i].sum);
      chk("single_valid_k1", out_valid, 1);
      chk("single_result", out_result, vecs[i].sum);
      chk("single_count_k1", count, 0);
      chk("single_alu_a_empty", alu_a, 0);
      cycle();
      chk("single_valid_k2", out_valid, 0);
      chk("single_result_hold", out_result, vecs[i].sum);
    end

    // Fill under back-pressure: first pair captured, next four fill the FIFO
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(i);
      in_b     = 8'(i);
      chk("fill_in_ready", in_ready, 1);
      cycle();
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready_full", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_first_result", out_result, 2);
    chk("fill_head_a", alu_a, 2);
    in_a = 8'd6;
    in_b = 8'd6;
    cycle();
    cycle();
    chk("fill_held_count", count, 4);
    chk("fill_held_result", out_result, 2);
    in_valid = 1'b0;
    exp_q = {};
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(2 * i));
    src_a[0] = 8'd6;
    src_b[0] = 8'd6;
    run_ops(1, 6, 0);
    chk("drain_cycles", ops_cycles, 6);

    // Streaming: (i, 2i) back-to-back, occupancy never above 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_a[i] = 8'(i);
      src_b[i] = 8'(2 * i);
    end
    exp_q = {};
    run_ops(8, 8, 0);
    chk("stream_cycles", ops_cycles, 10);
    chk("stream_max_count", max_cnt, 1);

    // Wrap-around: 3*DEPTH ops with random stalls
    do_reset();
    for (int i = 0; i < 12; i++) begin
      src_a[i] = 8'($urandom_range(255));
      src_b[i] = 8'($urandom_range(255));
    end
    exp_q = {};
    run_ops(12, 12, 40);
    chk("wrap_count_end", count, 0);
    chk("wrap_valid_end", out_valid, 0);

    // Reset mid-operation with count=3 and a pending result
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(i);
      in_b     = 8'(10);
      cycle();
    end
    chk("midrst_pre_count", count, 3);
    chk("midrst_pre_valid", out_valid, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    cycle();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    chk("midrst_no_ghost_valid", out_valid, 0);
    chk("midrst_no_ghost_count", count, 0);

`ifdef ALU_FEEDER_STATS_EN
    do_reset();
    chk("stats_rst", op_count, 0);
    for (int i = 0; i < 5; i++) begin
      src_a[i] = 8'(i + 1);
      src_b[i] = 8'(3);
    end
    exp_q = {};
    run_ops(5, 5, 0);
    chk("stats_five", op_count, 5);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'd1;
    in_b      = 8'd1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("stats_stall_valid", out_valid, 1);
    chk("stats_stall_hold", op_count, 5);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
